psg_write_scheduler: RTL



---
 rtl/psg_pkg.sv | 37 +++
 rtl/psg_rr_arbiter.sv | 41 ++++
 rtl/psg_write_scheduler.sv | 99 +++++++++
 3 files changed

// File: rtl/psg_pkg.sv
// Shared PSG register codes, byte formatters and scheduler state.
// Used by the write scheduler and its arbiter.
package psg_pkg;

  localparam logic [2:0] TONE0 = 3'b000;
  localparam logic [2:0] ATTN0 = 3'b001;
  localparam logic [2:0] TONE1 = 3'b010;
  localparam logic [2:0] ATTN1 = 3'b011;
  localparam logic [2:0] TONE2 = 3'b100;
  localparam logic [2:0] ATTN2 = 3'b101;
  localparam logic [2:0] NOISE = 3'b110;
  localparam logic [2:0] ATTN3 = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LATCH,
    ST_DATA
  } psg_state_e;

  function automatic logic is_tone(input logic [2:0] sel);
    return (sel[0] == 1'b0) && (sel != NOISE);
  endfunction

  function automatic logic [7:0] latch_byte(
    input logic [2:0] sel,
    input logic [9:0] value
  );
    if (sel == NOISE)
      return {1'b1, NOISE, 1'b0, value[2:0]};
    return {1'b1, sel, value[3:0]};
  endfunction

  function automatic logic [7:0] data_byte(input logic [5:0] hi);
    return {2'b00, hi};
  endfunction

endpackage

// File: rtl/psg_rr_arbiter.sv
// Two-way arbiter: round-robin (ARB_MODE=0) or req0-priority (ARB_MODE=1).
// Ports: req_valid in, xfer in (a grant was taken), gnt out (one-hot or 0).
module psg_rr_arbiter #(
  parameter int ARB_MODE = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_valid,
  input  logic       xfer,
  output logic [1:0] gnt
);

  // Index of the requester granted by the last accepted transfer.
  // Resets to 1 so req0 is favoured first.
  logic last_q;
  logic last_d;

  always_comb begin
    gnt = req_valid;
    if (req_valid == 2'b11) begin
      if (ARB_MODE == 1 || last_q)
        gnt = 2'b01;
      else
        gnt = 2'b10;
    end
  end

  always_comb begin
    last_d = last_q;
    if (xfer)
      last_d = gnt[1];
  end

  always_ff @(posedge clk) begin
    if (reset)
      last_q <= 1'b1;
    else
      last_q <= last_d;
  end

endmodule

// File: rtl/psg_write_scheduler.sv
// Arbitrates two register-write requesters and serialises each write into
// PSG latch/data bytes on psg_data; idles by re-latching attenuation 0.
// Ports: reqN_valid/ready/sel/value handshakes, psg_data byte, busy.
module psg_write_scheduler
  import psg_pkg::*;
#(
  parameter int         ARB_MODE        = 0,
  parameter logic [3:0] IDLE_RESET_ATTN = 4'hF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [2:0] req0_sel,
  input  logic [9:0] req0_value,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [2:0] req1_sel,
  input  logic [9:0] req1_value,
  output logic [7:0] psg_data,
  output logic       busy
);

  psg_state_e state_q, state_d;
  logic [7:0] data_q, data_d;
  logic [3:0] shadow_q, shadow_d;
  logic       tone_q, tone_d;
  logic [5:0] hi_q, hi_d;

  logic [1:0] gnt;
  logic       hold_tone;
  logic       can_accept;
  logic       xfer;
  logic [2:0] acc_sel;
  logic [9:0] acc_value;

  // A tone latch must be followed by its data byte, so nothing new
  // can be taken while one sits in LATCH.
  assign hold_tone  = (state_q == ST_LATCH) && tone_q;
  assign can_accept = !hold_tone;

  assign req0_ready = gnt[0] && can_accept && !reset;
  assign req1_ready = gnt[1] && can_accept && !reset;
  assign xfer = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  assign acc_sel   = req1_ready ? req1_sel   : req0_sel;
  assign acc_value = req1_ready ? req1_value : req0_value;

  assign psg_data = data_q;
  assign busy     = hold_tone;

  psg_rr_arbiter #(
    .ARB_MODE (ARB_MODE)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req_valid ({req1_valid, req0_valid}),
    .xfer      (xfer),
    .gnt       (gnt)
  );

  always_comb begin
    shadow_d = shadow_q;
    if (xfer && acc_sel == ATTN0)
      shadow_d = acc_value[3:0];

    state_d = ST_IDLE;
    data_d  = {1'b1, ATTN0, shadow_d};
    tone_d  = 1'b0;
    hi_d    = hi_q;

    if (hold_tone) begin
      state_d = ST_DATA;
      data_d  = data_byte(hi_q);
    end else if (xfer) begin
      state_d = ST_LATCH;
      data_d  = latch_byte(acc_sel, acc_value);
      tone_d  = is_tone(acc_sel);
      hi_d    = acc_value[9:4];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      data_q   <= {1'b1, ATTN0, IDLE_RESET_ATTN};
      shadow_q <= IDLE_RESET_ATTN;
      tone_q   <= 1'b0;
      hi_q     <= 6'd0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      shadow_q <= shadow_d;
      tone_q   <= tone_d;
      hi_q     <= hi_d;
    end
  end

endmodule
